bist_engine: RTL and testbench

- Self-contained built-in-self-test sequencer for multi-lane datapath DUTs such as matrix-mult arrays.
- Combines a Galois LFSR pattern driver, a MISR signature compactor, pattern/drain counters and a golden-signature comparator, all under one FSM.
- Generalises the fixed driver/monitor pair to an arbitrary lane count and width, with programmable pattern count, drain window, external-drive bypass and pass/fail.
- Sits between external test config and the DUT; one instance per DUT group.

---
 rtl/bist_engine.sv | 158 +++++++++++++++
 tb/tb_bist_engine.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bist_engine.sv
// Built-in self-test sequencer: Galois LFSR pattern driver, MISR compactor and golden compare.
// Optional macro BIST_LANE_MASK_EN adds lane_mask_i to exclude lanes from compaction.
module bist_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 8,
    parameter logic [WIDTH*LANES-1:0] POLY = 'hB8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   start_i,
    input  logic                   ext_bypass_i,
    input  logic [WIDTH*LANES-1:0] seed_i,
    input  logic [CNT_WIDTH-1:0]   num_patterns_i,
    input  logic [CNT_WIDTH-1:0]   drain_cycles_i,
    input  logic [WIDTH*LANES-1:0] golden_i,
    input  logic                   ext_valid_i,
    input  logic [WIDTH*LANES-1:0] ext_data_i,
    input  logic                   dut_valid_i,
    input  logic [WIDTH*LANES-1:0] dut_data_i,
`ifdef BIST_LANE_MASK_EN
    input  logic [LANES-1:0]       lane_mask_i,
`endif
    output logic                   drv_valid_o,
    output logic [WIDTH*LANES-1:0] drv_data_o,
    output logic [WIDTH*LANES-1:0] sig_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o
);

    localparam int unsigned D = WIDTH * LANES;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e               state_q;
    logic [D-1:0]         lfsr_q;
    logic [D-1:0]         misr_q;
    logic [D-1:0]         drv_data_q;
    logic                 drv_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [D-1:0]         seed_eff;
    logic [D-1:0]         lfsr_step;
    logic [D-1:0]         misr_d;
    logic [D-1:0]         dut_data_m;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 misr_en;
    logic                 run_last;
    logic                 drain_last;

    always_comb begin
        dut_data_m = dut_data_i;
`ifdef BIST_LANE_MASK_EN
        for (int l = 0; l < LANES; l++) begin
            if (!lane_mask_i[l]) begin
                dut_data_m[l*WIDTH +: WIDTH] = '0;
            end
        end
`endif
    end

    always_comb begin
        // An all-zero seed would lock the LFSR at zero forever.
        seed_eff   = (seed_i == '0) ? {{(D-1){1'b0}}, 1'b1} : seed_i;
        lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
        misr_en    = dut_valid_i && ((state_q == StRun) || (state_q == StDrain));
        misr_d     = misr_en ? (((misr_q >> 1) ^ (misr_q[0] ? POLY : '0)) ^ dut_data_m) : misr_q;
        cnt_inc    = cnt_q + 1'b1;
        run_last   = (cnt_q == num_patterns_i - 1'b1);
        drain_last = (drain_cycles_i == '0) || (cnt_q == drain_cycles_i - 1'b1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            lfsr_q      <= '0;
            misr_q      <= '0;
            drv_data_q  <= '0;
            drv_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cnt_q       <= '0;
        end else if (en_i) begin
            misr_q <= misr_d;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StLoad;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    lfsr_q <= seed_eff;
                    misr_q <= '0;
                    cnt_q  <= '0;
                    if (num_patterns_i != '0) begin
                        state_q     <= StRun;
                        drv_valid_q <= 1'b1;
                        drv_data_q  <= seed_eff;
                    end else begin
                        state_q <= StDrain;
                    end
                end
                StRun: begin
                    lfsr_q <= lfsr_step;
                    if (run_last) begin
                        state_q     <= StDrain;
                        cnt_q       <= '0;
                        drv_valid_q <= 1'b0;
                        drv_data_q  <= '0;
                    end else begin
                        cnt_q      <= cnt_inc;
                        drv_data_q <= lfsr_step;
                    end
                end
                StDrain: begin
                    if (drain_last) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Compare against the signature including this cycle's compaction.
                        pass_q  <= (misr_d == golden_i);
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StDone: begin
                    if (!start_i) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign drv_valid_o = ext_bypass_i ? ext_valid_i : drv_valid_q;
    assign drv_data_o  = ext_bypass_i ? ext_data_i : drv_data_q;
    assign sig_o       = misr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench for bist_engine at WIDTH=4, LANES=2, POLY=8'hB8.
module tb_bist_engine;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic        ext_bypass;
    logic [7:0]  seed;
    logic [15:0] num_patterns;
    logic [15:0] drain_cycles;
    logic [7:0]  golden;
    logic        ext_valid;
    logic [7:0]  ext_data;
    logic        dut_valid;
    logic [7:0]  dut_data;
    logic        drv_valid;
    logic [7:0]  drv_data;
    logic [7:0]  sig;
    logic        busy;
    logic        done;
    logic        pass;

    int errors = 0;
    int checks = 0;

    bist_engine #(
        .WIDTH     (4),
        .LANES     (2),
        .POLY      (8'hB8),
        .CNT_WIDTH (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .start_i        (start),
        .ext_bypass_i   (ext_bypass),
        .seed_i         (seed),
        .num_patterns_i (num_patterns),
        .drain_cycles_i (drain_cycles),
        .golden_i       (golden),
        .ext_valid_i    (ext_valid),
        .ext_data_i     (ext_data),
        .dut_valid_i    (dut_valid),
        .dut_data_i     (dut_data),
`ifdef BIST_LANE_MASK_EN
        .lane_mask_i    (2'b11),
`endif
        .drv_valid_o    (drv_valid),
        .drv_data_o     (drv_data),
        .sig_o          (sig),
        .busy_o         (busy),
        .done_o         (done),
        .pass_o         (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; ext_bypass = 1'b0;
        seed = 8'h00; num_patterns = 16'd0; drain_cycles = 16'd0; golden = 8'h00;
        ext_valid = 1'b0; ext_data = 8'h00; dut_valid = 1'b0; dut_data = 8'h00;
        tick();
        check("rst_valid", drv_valid, 0);
        check("rst_data", drv_data, 0);
        check("rst_sig", sig, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        rst = 1'b0;

        // Pattern sequence from seed 01, no drain
        seed = 8'h01; num_patterns = 16'd4; drain_cycles = 16'd0; golden = 8'h00; start = 1'b1;
        tick();
        check("load_busy", busy, 1);
        check("load_valid", drv_valid, 0);
        tick(); check("p0", {drv_valid, drv_data}, {1'b1, 8'h01});
        tick(); check("p1", {drv_valid, drv_data}, {1'b1, 8'hB8});
        tick(); check("p2", {drv_valid, drv_data}, {1'b1, 8'h5C});
        tick(); check("p3", {drv_valid, drv_data}, {1'b1, 8'h2E});
        tick();
        check("drain_valid", drv_valid, 0);
        check("drain_done", done, 0);
        tick();
        check("done_rise", {busy, done, pass}, 3'b011);

        // Held start keeps DONE
        for (int i = 0; i < 5; i++) begin
            tick();
            check("done_hold", done, 1);
        end
        start = 1'b0;
        tick();
        check("idle_clear", {busy, done, pass}, 3'b000);

        // Zero seed replaced by 1
        seed = 8'h00; num_patterns = 16'd2; start = 1'b1;
        tick();
        tick(); check("z0", {drv_valid, drv_data}, {1'b1, 8'h01});
        tick(); check("z1", {drv_valid, drv_data}, {1'b1, 8'hB8});
        tick(); check("z_drain", drv_valid, 0);
        tick(); check("z_done", done, 1);
        start = 1'b0;
        tick();

        // MISR compaction in DRAIN; pass for matching golden, fail otherwise
        for (int g = 0; g < 2; g++) begin
            seed = 8'h01; num_patterns = 16'd0; drain_cycles = 16'd2;
            golden = (g == 0) ? 8'hB9 : 8'hB8;
            start = 1'b1;
            tick();
            dut_valid = 1'b1; dut_data = 8'h01;
            tick();
            check("m_load_ignored", sig, 8'h00);
            check("m_drain_valid", drv_valid, 0);
            tick(); check("m_sig1", sig, 8'h01);
            tick();
            check("m_sig2", sig, 8'hB9);
            check("m_done", done, 1);
            check("m_pass", pass, (g == 0) ? 1 : 0);
            tick(); check("m_done_ignored", sig, 8'hB9);
            dut_valid = 1'b0; start = 1'b0;
            tick();
        end

        // Reset during RUN pattern 2, restart with start still high
        seed = 8'h01; num_patterns = 16'd4; drain_cycles = 16'd0; golden = 8'h00; start = 1'b1;
        tick(); tick(); tick(); tick();
        check("r_p2", drv_data, 8'h5C);
        rst = 1'b1;
        tick();
        check("r_out", {drv_valid, drv_data, sig, busy, done, pass}, 20'h0);
        rst = 1'b0;
        tick(); check("r_load", {busy, drv_valid}, 2'b10);
        tick(); check("r_p0", {drv_valid, drv_data}, {1'b1, 8'h01});
        tick(); tick(); tick(); tick(); tick();
        check("r_done", done, 1);
        start = 1'b0;
        tick();

        // Bypass is combinational in IDLE
        ext_bypass = 1'b1; ext_data = 8'h5A; ext_valid = 1'b1;
        #1;
        check("byp_on", {drv_valid, drv_data}, {1'b1, 8'h5A});
        ext_bypass = 1'b0;
        #1;
        check("byp_off", {drv_valid, drv_data}, {1'b0, 8'h00});

        // Freeze during RUN
        start = 1'b1;
        tick(); tick();
        check("f_p0", drv_data, 8'h01);
        tick();
        check("f_p1", drv_data, 8'hB8);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("f_hold", {drv_valid, drv_data}, {1'b1, 8'hB8});
        end
        en = 1'b1;
        tick(); check("f_p2", drv_data, 8'h5C);
        tick(); check("f_p3", {drv_valid, drv_data}, {1'b1, 8'h2E});
        tick(); check("f_end", drv_valid, 0);
        tick(); check("f_done", done, 1);
        start = 1'b0;
        tick();
        check("f_idle", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
